// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_bus_pkg
// Description : Shared CPU-bus definitions for the NES system: bus direction
//               encodings, well-known register addresses and the sprite DMA
//               state encoding, which doubles as the debug-port decode.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

   // CPU bus direction
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // Well-known register addresses
   localparam logic [15:0] ADDRESS_OAM_DMA  = 16'h4014;
   localparam logic [15:0] ADDRESS_OAM_DATA = 16'h2004;

   // Sprite DMA states; the numeric values appear on o_debug_state
   typedef enum logic [2:0] {
      DMA_IDLE  = 3'd0,
      DMA_HALT  = 3'd1,
      DMA_ALIGN = 3'd2,
      DMA_READ  = 3'd3,
      DMA_WRITE = 3'd4
   } dma_state_t;

endpackage : nes_bus_pkg
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : Sprite DMA engine. Snoops CPU writes; a write of page P to the
//               DMA register halts the CPU and copies $PP00-$PPFF into OAMDATA
//               as alternating read/write bus cycles (513 or 514 halt cycles
//               depending on bus-cycle parity at the start of the transfer).
//               All state advances on the falling edge of i_clk so it lines up
//               with the CPU's bus phasing.
// Ports       : i_clk          system clock, one CPU bus cycle per clock
//               i_reset        synchronous, active-high reset
//               i_cpu_rw       CPU read/write (1 = read)
//               i_cpu_address  CPU address
//               i_cpu_data     CPU write data (page number on trigger)
//               i_bus_data     bus read data during DMA read cycles
//               o_cpu_halt     1 = CPU halted, DMA owns the bus
//               o_rw           DMA read/write
//               o_address      DMA address
//               o_data         DMA write data
//               o_debug_state  current state encoding
//               o_debug_count  current byte index
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDRESS  = ADDRESS_OAM_DMA,
   parameter logic [15:0] OAM_DATA_ADDRESS = ADDRESS_OAM_DATA
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_cpu_address,
   input  logic [7:0]  i_cpu_data,
   input  logic [7:0]  i_bus_data,
   output logic        o_cpu_halt,
   output logic        o_rw,
   output logic [15:0] o_address,
   output logic [7:0]  o_data,
   output logic [2:0]  o_debug_state,
   output logic [7:0]  o_debug_count
);

   dma_state_t r_state;
   dma_state_t w_state_next;
   logic [7:0] r_page;
   logic [7:0] w_page_next;
   logic [7:0] r_count;
   logic [7:0] w_count_next;
   logic [7:0] r_data;
   logic [7:0] w_data_next;
   logic       r_parity;
   logic       w_trigger;

   assign w_trigger = (i_cpu_rw == RW_WRITE) && (i_cpu_address == DMA_REG_ADDRESS);

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         r_state  <= DMA_IDLE;
         r_page   <= 8'h00;
         r_count  <= 8'h00;
         r_data   <= 8'h00;
         r_parity <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_page   <= w_page_next;
         r_count  <= w_count_next;
         r_data   <= w_data_next;
         r_parity <= ~r_parity;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_page_next  = r_page;
      w_count_next = r_count;
      w_data_next  = r_data;
      o_rw         = RW_READ;
      o_address    = 16'h0000;
      o_data       = 8'h00;

      case (r_state)
         DMA_IDLE: begin
            if (w_trigger) begin
               w_page_next  = i_cpu_data;
               w_count_next = 8'h00;
               w_state_next = DMA_HALT;
            end
         end
         DMA_HALT: begin
            // An odd cycle here needs one dummy cycle so reads land on the
            // correct bus phase.
            w_state_next = r_parity ? DMA_ALIGN : DMA_READ;
         end
         DMA_ALIGN: begin
            w_state_next = DMA_READ;
         end
         DMA_READ: begin
            // Low byte is the count alone: no carry ever reaches the page.
            o_address    = {r_page, r_count};
            w_data_next  = i_bus_data;
            w_state_next = DMA_WRITE;
         end
         DMA_WRITE: begin
            o_rw         = RW_WRITE;
            o_address    = OAM_DATA_ADDRESS;
            o_data       = r_data;
            w_count_next = r_count + 8'd1;
            w_state_next = (r_count == 8'hFF) ? DMA_IDLE : DMA_READ;
         end
         default: begin
            w_state_next = DMA_IDLE;
         end
      endcase
   end

   assign o_cpu_halt    = (r_state != DMA_IDLE);
   assign o_debug_state = r_state;
   assign o_debug_count = r_count;

endmodule : oam_dma
`default_nettype wire
